// File: rtl/seg7_serial_decoder.sv
// seg7_serial_decoder
//   Receive side of the 7-segment output path. A 7-bit segment pattern
//   (bit0=a .. bit6=g, common-cathode, 1=lit) is shifted in MSB-first
//   (g first, a last). The pattern is then decoded back to a hex nibble,
//   and the block reports whether the frame was valid or in error.
//   All signals travel on the 8-bit TinyTapeout pins.
//
// Parameters
//   TIMEOUT     idle cycles (sen=0) tolerated mid-frame before the frame
//               is aborted; 0 disables the timeout
//
// Ports
//   io_in[0]    clk    rising-edge clock
//   io_in[1]    rst_n  asynchronous active-low reset
//   io_in[2]    sdata  serial segment bit, sampled when sen=1
//   io_in[3]    sen    shift enable / bit strobe
//   io_in[4]    inv    1 = pattern is active-low (inverted before decode)
//   io_in[5]    clr    synchronous clear
//   io_in[7:6]  unused
//   io_out[3:0] digit  last successfully decoded nibble
//   io_out[4]   valid  last completed frame matched the table
//   io_out[5]   err    last frame unrecognised or aborted by timeout
//   io_out[6]   done   one-cycle pulse when a frame is decoded
//   io_out[7]   busy   a frame is in progress (state != IDLE)
module seg7_serial_decoder #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    // The idle counter only has to reach TIMEOUT-1. The abort fires on the
    // idle cycle that would bring the count to TIMEOUT.
    localparam int unsigned TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [TW-1:0] TO_LAST = TO_LAST_I[TW-1:0];

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    logic clk;
    logic rst_n;
    logic sdata;
    logic sen;
    logic inv;
    logic clr;
    logic unused_pins;

    assign clk         = io_in[0];
    assign rst_n       = io_in[1];
    assign sdata       = io_in[2];
    assign sen         = io_in[3];
    assign inv         = io_in[4];
    assign clr         = io_in[5];
    assign unused_pins = ^io_in[7:6];

    state_t        state;
    logic [6:0]    shreg;
    logic [2:0]    bitcnt;
    logic [TW-1:0] tocnt;
    logic [3:0]    digit;
    logic          valid;
    logic          err;
    logic          done;

    logic [6:0]    pat;
    logic          hit;
    logic [3:0]    nib;

    // inv is sampled in the DONE cycle itself, so it is applied here
    // and not while the bits are shifted in.
    assign pat = shreg ^ {7{inv}};

    always_comb begin
        hit = 1'b1;
        nib = '0;
        case (pat)
            7'h3F:   nib = 4'h0;
            7'h06:   nib = 4'h1;
            7'h5B:   nib = 4'h2;
            7'h4F:   nib = 4'h3;
            7'h66:   nib = 4'h4;
            7'h6D:   nib = 4'h5;
            7'h7D:   nib = 4'h6;
            7'h07:   nib = 4'h7;
            7'h7F:   nib = 4'h8;
            7'h6F:   nib = 4'h9;
            7'h77:   nib = 4'hA;
            7'h7C:   nib = 4'hB;
            7'h39:   nib = 4'hC;
            7'h5E:   nib = 4'hD;
            7'h79:   nib = 4'hE;
            7'h71:   nib = 4'hF;
            default: hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            tocnt  <= '0;
            digit  <= '0;
            valid  <= 1'b0;
            err    <= 1'b0;
            done   <= 1'b0;
        end else if (clr) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            tocnt  <= '0;
            digit  <= '0;
            valid  <= 1'b0;
            err    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sen) begin
                        shreg  <= {6'b000000, sdata};
                        bitcnt <= 3'd1;
                        tocnt  <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sen) begin
                        shreg  <= {shreg[5:0], sdata};
                        bitcnt <= bitcnt + 3'd1;
                        tocnt  <= '0;
                        if (bitcnt == 3'd6) begin
                            state <= DONE;
                        end
                    end else if (TIMEOUT != 0) begin
                        if (tocnt == TO_LAST) begin
                            // Abort: partial frame dropped, digit kept.
                            state  <= IDLE;
                            bitcnt <= '0;
                            tocnt  <= '0;
                            valid  <= 1'b0;
                            err    <= 1'b1;
                        end else begin
                            tocnt <= tocnt + TW'(1);
                        end
                    end
                end
                DONE: begin
                    if (hit) begin
                        digit <= nib;
                        valid <= 1'b1;
                        err   <= 1'b0;
                    end else begin
                        valid <= 1'b0;
                        err   <= 1'b1;
                    end
                    done   <= 1'b1;
                    bitcnt <= '0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign io_out = {(state != IDLE), done, err, valid, digit};

endmodule

// File: tb/tb_seg7_serial_decoder.sv
module tb_seg7_serial_decoder;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       sdata = 1'b0;
    logic       sen   = 1'b0;
    logic       inv   = 1'b0;
    logic       clr   = 1'b0;
    logic [1:0] spare = 2'b00;
    logic [7:0] io_in;
    logic [7:0] out_a;
    logic [7:0] out_b;

    assign io_in = {spare, clr, inv, sen, sdata, rst_n, clk};

    seg7_serial_decoder #(.TIMEOUT(255)) dut_a (.io_in(io_in), .io_out(out_a));
    seg7_serial_decoder #(.TIMEOUT(4))   dut_b (.io_in(io_in), .io_out(out_b));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    bit [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Behavioural model: a frame is a count of collected bits plus a
    // "decode pending" flag for the cycle after the 7th bit.
    typedef struct {
        int       nbits;
        bit [6:0] bits;
        int       idle;
        bit       pend;
        bit [3:0] digit;
        bit       valid;
        bit       err;
        bit       done;
    } mstate_t;

    mstate_t m [2];

    function automatic mstate_t mstep(mstate_t s, int t, logic sd, logic se, logic iv, logic cl);
        mstate_t n;
        bit [6:0] p;
        bit found;
        n = s;
        n.done = 1'b0;
        if (cl) begin
            n = '{default: 0};
        end else if (s.pend) begin
            n.pend = 1'b0;
            p = s.bits ^ {7{iv}};
            found = 1'b0;
            for (int d = 0; d < 16; d++) begin
                if (seg_tab[d] == p) begin
                    found = 1'b1;
                    n.digit = d[3:0];
                end
            end
            n.valid = found;
            n.err   = !found;
            n.done  = 1'b1;
        end else if (se) begin
            if (s.nbits == 0) n.bits = '0;
            n.bits  = {n.bits[5:0], sd};
            n.nbits = s.nbits + 1;
            n.idle  = 0;
            if (n.nbits == 7) begin
                n.nbits = 0;
                n.pend  = 1'b1;
            end
        end else if (s.nbits > 0) begin
            n.idle = s.idle + 1;
            if (t != 0 && n.idle == t) begin
                n.nbits = 0;
                n.idle  = 0;
                n.err   = 1'b1;
                n.valid = 1'b0;
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] exp_out(mstate_t s);
        logic busy;
        busy = (s.nbits > 0) || s.pend;
        return {busy, s.done, s.err, s.valid, s.digit};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m[0] = '{default: 0};
            m[1] = '{default: 0};
        end else begin
            m[0] = mstep(m[0], 255, sdata, sen, inv, clr);
            m[1] = mstep(m[1], 4,   sdata, sen, inv, clr);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_a", out_a, exp_out(m[0]));
            check("model_b", out_b, exp_out(m[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive_bit(input logic b);
        sen   = 1'b1;
        sdata = b;
        tick();
        sen   = 1'b0;
        sdata = 1'b0;
    endtask

    task automatic send_frame(input logic [6:0] p, input logic iv);
        inv = iv;
        for (int i = 6; i >= 0; i--) drive_bit(p[i]);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] p;
        logic [7:0] rnd;
        logic       iv;

        // Reset with random input activity
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rnd   = 8'($urandom);
            sdata = rnd[2];
            sen   = rnd[3];
            inv   = rnd[4];
            clr   = rnd[5];
            spare = rnd[7:6];
            tick();
            check("reset_a", out_a, 8'h00);
            check("reset_b", out_b, 8'h00);
        end
        {sdata, sen, inv, clr, spare} = '0;
        rst_n = 1'b1;
        idle(3);
        check("idle_after_reset", out_a, 8'h00);

        // 0x5B, busy during shift, then done pulse and steady state
        inv = 1'b0;
        p = 7'h5B;
        for (int i = 6; i >= 0; i--) begin
            drive_bit(p[i]);
            if (i == 6) check("busy_first_bit", {7'b0, out_a[7]}, 8'h01);
        end
        check("busy_done_cycle", {7'b0, out_a[7]}, 8'h01);
        tick();
        check("done_pulse_5b", out_a, 8'h52);
        tick();
        check("steady_5b", out_a, 8'h12);

        // 0x79 plain then inverted
        send_frame(7'h79, 1'b0);
        idle(2);
        check("steady_79", out_a, 8'h1E);
        send_frame(7'h79, 1'b1);
        idle(2);
        check("steady_79_inv", out_a, 8'h11);
        inv = 1'b0;

        // Unrecognised pattern keeps the previous digit
        send_frame(7'h5B, 1'b0);
        idle(2);
        check("steady_5b_again", out_a, 8'h12);
        send_frame(7'h00, 1'b0);
        tick();
        check("err_pulse", out_a, 8'h62);
        tick();
        check("err_steady", out_a, 8'h22);

        // Timeout on the TIMEOUT=4 instance
        pulse_clr();
        check("clr_a", out_a, 8'h00);
        check("clr_b", out_b, 8'h00);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) check("busy_before_timeout", {7'b0, out_b[7]}, 8'h01);
            else       check("timeout_abort", out_b, 8'h20);
        end
        send_frame(7'h3F, 1'b0);
        tick();
        check("after_timeout_pulse", out_b, 8'h50);
        tick();
        check("after_timeout_steady", out_b, 8'h10);
        pulse_clr();

        // Async reset mid-frame, then clr mid-frame
        send_frame(7'h5B, 1'b0);
        idle(2);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check("async_reset_a", out_a, 8'h00);
        check("async_reset_b", out_b, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        pulse_clr();
        check("clr_mid_a", out_a, 8'h00);
        check("clr_mid_b", out_b, 8'h00);
        send_frame(7'h06, 1'b0);
        idle(2);
        check("after_clr_a", out_a, 8'h11);
        check("after_clr_b", out_b, 8'h11);

        // Randomized frames with occasional gaps and clears
        for (int f = 0; f < 300; f++) begin
            iv = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) p = seg_tab[$urandom_range(0, 15)];
            else                           p = 7'($urandom);
            if (iv) p = ~p;
            inv = iv;
            for (int i = 6; i >= 0; i--) begin
                if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 6));
                if ($urandom_range(0, 99) == 0) pulse_clr();
                drive_bit(p[i]);
            end
            idle($urandom_range(2, 4));
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
